updn_sweep_ctrl: RTL
====================

Name: updn_sweep_ctrl

Overview:
Sequencer for the 16-bit up/down counter (`dut`: data_in, rst_, ld_cnt, updn_cnt, count_enb, clk, data_out). On a start command it loads a low bound into the counter. It then drives a triangle sweep lo→hi→lo for a programmed number of sweeps, using the counter's data_out for turn-around decisions. It reports busy/done/err and sits between the test/config logic and the counter instance.

Parameters:
WIDTH, 16, counter and bound width
SWEEP_W, 8, width of sweep-count configuration

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  single-cycle request; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE
pause  in  1  freezes sweep (counter held, state held)
cfg_lo  in  WIDTH  sweep low bound, latched on accepted start
cfg_hi  in  WIDTH  sweep high bound, latched on accepted start
cfg_sweeps  in  SWEEP_W  number of full up+down sweeps, latched on start
cnt_value  in  WIDTH  counter data_out
cnt_rst_  out  1  counter active-low reset = !rst (combinational)
cnt_data_in  out  WIDTH  counter load value
cnt_ld  out  1  counter ld_cnt
cnt_updn  out  1  counter updn_cnt (1=up)
cnt_enb  out  1  counter count_enb
busy  out  1  high in LOAD/UP/DOWN
done  out  1  one-cycle pulse on sweep completion
err  out  1  one-cycle pulse on rejected start

Behaviour:
- Counter contract: registered; on an edge, ld_cnt has priority (data_out<=data_in), else if count_enb data_out±1 per updn_cnt, else hold.
- Reset (rst=1 at an edge): state IDLE; busy/done/err/cnt_ld/cnt_enb/cnt_updn=0, cnt_data_in=0, latched config=0.
- States: IDLE, LOAD, UP, DOWN, DONE. Outputs are Moore decodes of state plus the latched lo.
- IDLE: all counter controls 0.
  - start with cfg_hi>cfg_lo and cfg_sweeps!=0: latch config, remaining=cfg_sweeps, go to LOAD.
  - Otherwise start pulses err next cycle and the block stays IDLE.
- LOAD (1 cycle): cnt_ld=1, cnt_data_in=lo, cnt_enb=0 → UP.
- UP: cnt_enb=1, cnt_updn=1. When cnt_value==hi-1 → DOWN, so the counter peaks at hi exactly.
- DOWN: cnt_enb=1, cnt_updn=0. When cnt_value==lo+1 the counter reaches lo; then if remaining==1 → DONE, else remaining-- and → UP.
- DONE (1 cycle): done=1, controls 0 → IDLE. The counter holds lo.
- pause=1 in UP/DOWN: cnt_enb=0, state and remaining frozen, turn-around compares suppressed. In LOAD, pause is ignored.
- abort=1 in any non-IDLE state: next state IDLE, no done pulse, counter holds current value. Abort has priority over pause. If abort and start arrive in IDLE together, start is ignored.
- start while busy: ignored, no err.
- hi==lo+1: one UP cycle per sweep. hi=2^WIDTH-1 is legal; no wrap-around ever occurs.
- Latency: accepted start at edge k → LOAD at k+1 → first UP at k+2. Without pause, done asserts at k+2+2·N·(hi−lo).
- Reset mid-sweep returns to IDLE. cnt_rst_ drops the same cycle, clearing the counter.

Decomposition:
- Package updn_sweep_pkg: state enum (IDLE, LOAD, UP, DOWN, DONE), WIDTH/SWEEP_W defaults.
- No sub-module needed. The counter `dut` is instantiated alongside the controller, not inside it.

Test Plan:
- Nominal sweep: lo=3, hi=7, sweeps=2, start at cycle 0 → cnt_value 3,4,5,6,7,6,5,4,3,4…7…3; done pulse at cycle 18; busy high cycles 1–17.
- Config rejection: lo=7, hi=7 → err pulse at cycle 1, busy stays 0, counter untouched. Repeat with sweeps=0, same result.
- Pause: pause high 3 cycles during UP at cnt_value=5 → cnt_value holds 5 for 3 cycles; done delayed by exactly 3 cycles.
- Abort: abort in DOWN at cnt_value=6 → IDLE next cycle, cnt_value stays 6, no done pulse. A new start then loads lo.
- Reset mid-sweep: rst at cnt_value=5 → all outputs 0 next cycle, cnt_rst_=0 while rst=1. A start after reset runs nominally.
- Boundary: lo=16'hFFFE, hi=16'hFFFF, sweeps=1 → values FFFE, FFFF, FFFE; done at cycle 4; no wrap-around.

Source files
------------

// File: rtl/updn_sweep_pkg.sv
// rtl/updn_sweep_pkg.sv - shared state encoding and default widths for the up/down sweep sequencer
package updn_sweep_pkg;

    localparam int WIDTH_DEF   = 16;
    localparam int SWEEP_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_UP   = 3'd2,
        ST_DOWN = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/updn_sweep_ctrl_if.sv
// rtl/updn_sweep_ctrl_if.sv - control bus between the sweep sequencer and the up/down counter
interface updn_sweep_ctrl_if
    import updn_sweep_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    logic [WIDTH-1:0] cnt_value;
    logic             cnt_rst_;
    logic [WIDTH-1:0] cnt_data_in;
    logic             cnt_ld;
    logic             cnt_updn;
    logic             cnt_enb;

    modport master (
        input  cnt_value,
        output cnt_rst_, cnt_data_in, cnt_ld, cnt_updn, cnt_enb
    );

    modport slave (
        output cnt_value,
        input  cnt_rst_, cnt_data_in, cnt_ld, cnt_updn, cnt_enb
    );

endinterface

// File: rtl/updn_sweep_ctrl.sv
// rtl/updn_sweep_ctrl.sv - drives an external up/down counter through lo->hi->lo triangle sweeps
module updn_sweep_ctrl
    import updn_sweep_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SWEEP_W = SWEEP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic [WIDTH-1:0]   cfg_lo,
    input  logic [WIDTH-1:0]   cfg_hi,
    input  logic [SWEEP_W-1:0] cfg_sweeps,
    updn_sweep_ctrl_if.master  cnt_bus,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [2:0] IDLE = ST_IDLE;
    localparam logic [2:0] LOAD = ST_LOAD;
    localparam logic [2:0] UP   = ST_UP;
    localparam logic [2:0] DOWN = ST_DOWN;
    localparam logic [2:0] DONE = ST_DONE;

    logic [2:0]         state, state_nx;
    logic [WIDTH-1:0]   lo_q, hi_q;
    logic [SWEEP_W-1:0] rem_q, rem_nx;
    logic               err_q;
    logic               cfg_ok, accept, sweeping;

    assign cfg_ok   = (cfg_hi > cfg_lo) && (cfg_sweeps != '0);
    assign accept   = (state == IDLE) && start && !abort && cfg_ok;
    assign sweeping = (state == UP) || (state == DOWN);

    // Turn-around is decided one count early so the counter lands exactly on hi/lo.
    always_comb begin
        state_nx = state;
        rem_nx   = rem_q;
        case (state)
            IDLE: if (accept) state_nx = LOAD;
            LOAD: state_nx = UP;
            UP: begin
                if (!pause && cnt_bus.cnt_value == hi_q - WIDTH'(1))
                    state_nx = DOWN;
            end
            DOWN: begin
                if (!pause && cnt_bus.cnt_value == lo_q + WIDTH'(1)) begin
                    if (rem_q == SWEEP_W'(1)) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = UP;
                        rem_nx   = rem_q - SWEEP_W'(1);
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_nx = IDLE;
            rem_nx   = rem_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lo_q  <= '0;
            hi_q  <= '0;
            rem_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nx;
            err_q <= (state == IDLE) && start && !abort && !cfg_ok;
            if (accept) begin
                lo_q  <= cfg_lo;
                hi_q  <= cfg_hi;
                rem_q <= cfg_sweeps;
            end else begin
                rem_q <= rem_nx;
            end
        end
    end

    // Abort gates the counter controls so it holds its value on the abort cycle.
    assign cnt_bus.cnt_rst_    = !rst;
    assign cnt_bus.cnt_ld      = (state == LOAD) && !abort;
    assign cnt_bus.cnt_data_in = (state == LOAD) ? lo_q : '0;
    assign cnt_bus.cnt_updn    = (state == UP);
    assign cnt_bus.cnt_enb     = sweeping && !pause && !abort;

    assign busy = (state == LOAD) || sweeping;
    assign done = (state == DONE);
    assign err  = err_q;

endmodule
